// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between instruction fetch and data load/store requesters.
// Each access runs issue -> fixed-latency wait -> one-cycle done; data has priority.
module mem_port_arbiter #(
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 16,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_done_o,
    output logic [DW-1:0] if_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_done_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          busy_o
);

    localparam int unsigned CntW = $clog2(MEM_LAT + 1);
    localparam int unsigned SW   = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] LatInit   = CntW'(MEM_LAT);
    localparam logic [SW-1:0]   StarveTop = SW'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;  // 1 = data, 0 = fetch
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [CntW-1:0] wait_q, wait_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            fetch_win;

    assign fetch_win = if_req_i && (!d_req_i || (starve_q == StarveTop));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        wait_d     = wait_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            StIdle: begin
                if (if_req_i || d_req_i) begin
                    state_d = StIssue;
                    owner_d = !fetch_win;
                    addr_d  = fetch_win ? if_addr_i : d_addr_i;
                    we_d    = !fetch_win && d_we_i;
                    wdata_d = d_wdata_i;
                    // Count only data grants that held off a pending fetch.
                    if (fetch_win || !if_req_i) begin
                        starve_d = '0;
                    end else if (starve_q != StarveTop) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            StIssue: begin
                wait_d  = LatInit;
                state_d = StWait;
            end
            StWait: begin
                wait_d = wait_q - CntW'(1);
                if (wait_q == CntW'(1)) begin
                    state_d = StDone;
                    if (!owner_q) begin
                        if_rdata_d = mem_rdata_i;
                    end else if (!we_q) begin
                        d_rdata_d = mem_rdata_i;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wait_q     <= '0;
            starve_q   <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            wait_q     <= wait_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem_en_o    = (state_q == StIssue);
    assign mem_we_o    = (state_q == StIssue) && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_done_o   = (state_q == StDone) && !owner_q;
    assign d_done_o    = (state_q == StDone) && owner_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance for most steps and a
// MEM_LAT=1 instance for back-to-back loads, both fed by a latency-accurate memory model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic        if_done, d_done, mem_en, mem_we, busy;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        if_req1, d_req1, d_we1;
    logic [15:0] if_addr1, d_addr1, d_wdata1;
    logic        if_done1, d_done1, mem_en1, mem_we1, busy1;
    logic [15:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    int checks = 0;
    int errors = 0;
    logic [16:0] sb_q[$];  // {is_data, expected rdata}
    logic [15:0] p0, p1, q0;
    logic [15:0] addrs[4];

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_done_o(if_done), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_done_o(d_done), .d_rdata_o(d_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req1), .if_addr_i(if_addr1), .if_done_o(if_done1),
        .if_rdata_o(if_rdata1),
        .d_req_i(d_req1), .d_we_i(d_we1), .d_addr_i(d_addr1), .d_wdata_i(d_wdata1),
        .d_done_o(d_done1), .d_rdata_o(d_rdata1),
        .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
        .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata1), .busy_o(busy1)
    );

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hABCD : ((a ^ 16'hC35A) + 16'h0101);
    endfunction

    // Read data valid exactly MEM_LAT cycles after mem_en; junk otherwise.
    always_ff @(posedge clk) begin
        p0 <= (mem_en && !mem_we) ? mem_f(mem_addr) : 16'hDEAD;
        p1 <= p0;
        q0 <= (mem_en1 && !mem_we1) ? mem_f(mem_addr1) : 16'hDEAD;
    end
    assign mem_rdata  = p1;
    assign mem_rdata1 = q0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(if_done || d_done) && n < 20);
        chk("done_seen", {31'd0, if_done | d_done}, 32'd1);
        chk("done_excl", {31'd0, if_done & d_done}, 32'd0);
    endtask

    task automatic check_done(input string tag);
        logic [16:0] e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_d_done"}, {31'd0, d_done}, {31'd0, e[16]});
            chk({tag, "_if_done"}, {31'd0, if_done}, {31'd0, !e[16]});
            chk({tag, "_rdata"}, {16'd0, (e[16] ? d_rdata : if_rdata)}, {16'd0, e[15:0]});
        end
    endtask

    initial begin
        int n;
        int nd;
        int last_en;
        logic seen;
        logic [16:0] e;
        addrs[0] = 16'h0500; addrs[1] = 16'h0501; addrs[2] = 16'h0777; addrs[3] = 16'h1234;
        if_req1 = 0; if_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0;

        // Reset with both requests up.
        rst = 1; if_req = 1; if_addr = 16'h0040; d_req = 1; d_we = 0;
        d_addr = 16'h0100; d_wdata = 16'h9999;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end
        chk("rst_outs", {if_done, d_done, mem_we, mem_addr, mem_wdata}, 32'd0);
        chk("rst_rdata", {if_rdata, d_rdata}, 32'd0);
        rst = 0;
        tick();
        chk("rel_grant_en", {31'd0, mem_en}, 32'd1);
        chk("rel_grant_we", {31'd0, mem_we}, 32'd0);
        chk("rel_grant_addr", {16'd0, mem_addr}, 32'h0100);
        if_req = 0;
        sb_q.push_back({1'b1, mem_f(16'h0100)});
        wait_done(n);
        chk("rel_latency", n, 3);
        check_done("rel_load");
        d_req = 0;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Fetch only.
        if_req = 1; if_addr = 16'h0010;
        tick();
        chk("f_en", {31'd0, mem_en}, 32'd1);
        chk("f_we", {31'd0, mem_we}, 32'd0);
        chk("f_addr", {16'd0, mem_addr}, 32'h0010);
        sb_q.push_back({1'b0, 16'hABCD});
        wait_done(n);
        chk("f_latency", n, 3);
        check_done("fetch");
        if_req = 0;
        tick();

        // Store: d_rdata must keep the earlier load value.
        d_req = 1; d_we = 1; d_addr = 16'h0200; d_wdata = 16'h1234;
        tick();
        chk("s_en", {31'd0, mem_en}, 32'd1);
        chk("s_we", {31'd0, mem_we}, 32'd1);
        chk("s_addr", {16'd0, mem_addr}, 32'h0200);
        chk("s_wdata", {16'd0, mem_wdata}, 32'h1234);
        tick();
        chk("s_we_after", {31'd0, mem_we}, 32'd0);
        sb_q.push_back({1'b1, mem_f(16'h0100)});
        wait_done(n);
        chk("s_latency", n, 2);
        check_done("store");
        d_req = 0; d_we = 0;
        tick();

        // Reset in the middle of a load.
        d_req = 1; d_addr = 16'h0300;
        tick();
        tick();
        rst = 1;
        tick();
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_en", {31'd0, mem_en}, 32'd0);
        chk("mr_d_rdata", {16'd0, d_rdata}, 32'd0);
        chk("mr_if_rdata", {16'd0, if_rdata}, 32'd0);
        rst = 0; d_req = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | d_done | if_done | mem_en;
        end
        chk("mr_no_activity", {31'd0, seen}, 32'd0);
        chk("mr_d_rdata_late", {16'd0, d_rdata}, 32'd0);

        // Starvation guard: both held; every fifth grant goes to fetch.
        if_addr = 16'h0040; d_addr = 16'h0300; d_we = 0;
        for (int g = 0; g < 10; g++) begin
            if (g % 5 == 4) sb_q.push_back({1'b0, mem_f(16'h0040)});
            else sb_q.push_back({1'b1, mem_f(16'h0300)});
        end
        if_req = 1; d_req = 1;
        for (int g = 0; g < 10; g++) begin
            wait_done(n);
            chk("sv_spacing", n, (g == 0) ? 4 : 5);
            check_done("starve");
        end
        if_req = 0; d_req = 0;
        tick();

        // Back-to-back loads on the MEM_LAT=1 instance.
        d_addr1 = addrs[0]; d_req1 = 1;
        sb_q.push_back({1'b1, mem_f(addrs[0])});
        nd = 0;
        last_en = -1;
        for (int c = 0; c < 60 && nd < 4; c++) begin
            tick();
            if (mem_en1) begin
                if (last_en >= 0) chk("b2b_en_spacing", c - last_en, 4);
                last_en = c;
            end
            if (d_done1) begin
                e = sb_q.pop_front();
                chk("b2b_rdata", {16'd0, d_rdata1}, {16'd0, e[15:0]});
                chk("b2b_no_if_done", {31'd0, if_done1}, 32'd0);
                nd++;
                if (nd < 4) begin
                    d_addr1 = addrs[nd];
                    sb_q.push_back({1'b1, mem_f(addrs[nd])});
                end else begin
                    d_req1 = 0;
                end
            end
        end
        chk("b2b_count", nd, 4);
        chk("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one single-ported unified memory between two requesters: the control FSM's instruction-fetch path (IF state) and its data path (load/store MEM states). Each access is sequenced as issue, a fixed-latency wait, then a one-cycle completion pulse carrying read data. Data accesses have priority, and a starvation guard bounds how long a pending fetch can be held off. The block sits between the control/datapath and the memory macro, replacing the separate instruction and data memory ports.

Parameters:
AW, 16, address width
DW, 16, data width
MEM_LAT, 2, cycles from the mem_en cycle until mem_rdata is valid (>=1)
STARVE_MAX, 4, consecutive data grants taken while if_req is pending before fetch is forced (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch request; held with if_addr stable until if_done
if_addr  in  AW  fetch address
if_done  out  1  one-cycle pulse; if_rdata valid in same cycle
if_rdata  out  DW  fetched word; held until next fetch completion
d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_done  out  1  one-cycle pulse at load/store completion
d_rdata  out  DW  load data; updated only by loads
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst high at an edge): state=IDLE. All outputs 0, including rdata registers, latched request fields, wait counter and starvation counter. Requests present during rst are ignored. An in-flight access is abandoned, with no done pulse and late mem_rdata discarded.
- States: IDLE, ISSUE, WAIT, DONE (Moore outputs, decoded from state and latched fields).
- IDLE:
  - No request: stay in IDLE.
  - Otherwise choose a winner. Latch owner, addr, we (fetch forces we=0) and wdata, then go to ISSUE.
- Priority:
  - Data wins unless if_req=1 and starve_cnt==STARVE_MAX, in which case fetch wins.
  - starve_cnt: +1 on a data grant while if_req=1; cleared on any fetch grant or on a data grant with if_req=0; saturates at STARVE_MAX.
- ISSUE (1 cycle): mem_en=1, mem_we=latched we, mem_addr/mem_wdata = latched values. Set wait counter=MEM_LAT, go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle where the counter is 1:
  - Capture mem_rdata into if_rdata (fetch) or d_rdata (load); stores capture nothing.
  - Go to DONE.
- DONE (1 cycle): owner's done=1, then go to IDLE. Requests are not sampled in DONE. The requester must drop or replace its request by the following cycle.
- Latency: request sampled in IDLE at cycle t → mem_en at t+1 → done at t+2+MEM_LAT. Minimum spacing between mem_en pulses is 3+MEM_LAT cycles.
- Outside ISSUE: mem_en=0 and mem_we=0; mem_addr/mem_wdata hold their latched values.
- Input changes after grant have no effect on the current access.
- if_done and d_done are never high in the same cycle.
- busy=0 only in IDLE.

Test Plan:
- Reset: hold rst 3 cycles with if_req=d_req=1 → all outputs 0, no mem_en. Release → the first grant goes to data (mem_we=d_we, mem_addr=d_addr) one cycle after the IDLE sample.
- Fetch only, MEM_LAT=2: if_req at cycle 0, if_addr=0x0010, memory returns 0xABCD → mem_en=1, mem_we=0, mem_addr=0x0010 at cycle 1. if_done=1 with if_rdata=0xABCD at cycle 4; d_done stays 0.
- Store: d_req, d_we=1, d_addr=0x0200, d_wdata=0x1234 → mem_en=mem_we=1 at cycle 1 with those values. d_done at cycle 4; d_rdata unchanged.
- Starvation, STARVE_MAX=4: both requests held continuously, each re-raised the cycle after done → data granted 4 times, 5th grant goes to fetch, starve_cnt returns to 0, 6th grant goes to data.
- Reset mid-WAIT: assert rst at cycle 2 of a load → no d_done. State=IDLE and mem_en=0 from cycle 3; d_rdata=0.
- Back-to-back loads, MEM_LAT=1: d_req re-asserted the cycle after each d_done → mem_en pulses exactly 4 cycles apart, with each d_rdata matching its address's memory content.
